// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V instruction fetch stage. Owns the PC, fetches words over a
// req/gnt/rvalid port and buffers them in a small FIFO for the decode stage.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pcplus4,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t            state;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   inflight_pc;
  logic [XLEN-1:0]   fifo_pc    [DEPTH];
  logic [31:0]       fifo_instr [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              space;
  logic              accept;
  logic              push;
  logic              pop;
  logic              redirect_pc_unused;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // An outstanding request already owns a FIFO slot, so a new fetch needs room beyond it.
  assign occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, state != S_REQ};
  assign space       = occupancy < (CNT_W + 1)'(DEPTH);
  assign o_imem_req  = space && !i_redirect &&
                       (state == S_REQ || (state == S_WAIT && i_imem_rvalid));
  assign o_imem_addr = fetch_pc;
  assign accept      = o_imem_req && i_imem_gnt;
  assign push        = (state == S_WAIT) && i_imem_rvalid && !i_redirect;

  assign o_valid   = (count != '0);
  assign pop       = o_valid && i_ready && !i_redirect;
  assign o_instr   = o_valid ? fifo_instr[rd_ptr] : NOP;
  assign o_pc      = o_valid ? fifo_pc[rd_ptr] : '0;
  assign o_pcplus4 = o_pc + XLEN'(4);

  assign redirect_pc_unused = ^i_redirect_pc[1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_REQ;
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
    end else if (i_redirect) begin
      fetch_pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
      // A request still in flight must have its response swallowed in DROP.
      if (state != S_REQ) state <= i_imem_rvalid ? S_REQ : S_DROP;
    end else begin
      if (accept) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
      case (state)
        S_REQ:   if (accept) state <= S_WAIT;
        S_WAIT:  if (i_imem_rvalid) state <= accept ? S_WAIT : S_REQ;
        S_DROP:  if (i_imem_rvalid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= inflight_pc;
      fifo_instr[wr_ptr] <= i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized bench for fetch_unit, checked every cycle
// against a queue-based behavioural model driven by a latency-programmable memory.
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_instr       (instr),
    .o_pc          (pc),
    .o_pcplus4     (pcplus4),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc)
  );

  // Model: FIFO contents as queues, plus one optional outstanding fetch that may be marked discarded.
  logic [31:0] mq_pc[$];
  logic [31:0] mq_instr[$];
  bit          m_out;
  bit          m_disc;
  bit          m_req;
  logic [31:0] m_out_pc;
  logic [31:0] m_next_pc;

  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  int          lat_lo = 1, lat_hi = 1, gnt_pct = 100, rdy_pct = 100, redir_pct = 0;
  bit          force_redirect;
  logic [31:0] force_target;
  bit          seq_on;
  int          seq_n;
  int          errors = 0;
  int          checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mq_pc.delete();
    mq_instr.delete();
    m_out     = 1'b0;
    m_disc    = 1'b0;
    m_out_pc  = 32'h0;
    m_next_pc = RESET_PC;
  endtask

  function automatic logic [31:0] pickTarget();
    if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 | ($urandom & 32'hF);
    return $urandom & 32'h0000_0FFF;
  endfunction

  task automatic applyStimulus();
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    ready       = ($urandom_range(99) < rdy_pct);
    redirect    = force_redirect || ($urandom_range(99) < redir_pct);
    redirect_pc = force_redirect ? force_target : pickTarget();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_addr | 32'h0000_A000;
      end
    end
  endtask

  task automatic compareModel();
    int          sz;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    sz        = mq_pc.size();
    m_req     = ((sz + int'(m_out)) < DEPTH) && !redirect && (!m_out || (!m_disc && imem_rvalid));
    exp_pc    = (sz != 0) ? mq_pc[0] : 32'h0;
    exp_instr = (sz != 0) ? mq_instr[0] : 32'h0000_0013;
    checkOutput("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) checkOutput("imem_addr", imem_addr, m_next_pc);
    checkOutput("valid", 32'(valid), 32'(sz != 0));
    checkOutput("pc", pc, exp_pc);
    checkOutput("instr", instr, exp_instr);
    checkOutput("pcplus4", pcplus4, exp_pc + 32'd4);
    checkOutput("single_outstanding", 32'(imem_req && imem_gnt && mem_busy && !imem_rvalid), 32'd0);
    if (seq_on && valid && ready && !redirect) begin
      checkOutput("seq_pc", pc, 32'(seq_n * 4));
      seq_n++;
    end
  endtask

  task automatic updateModel();
    bit accept;
    bit pop;
    if (imem_rvalid) mem_busy = 1'b0;
    if (rst_n && imem_req && imem_gnt) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = int'($urandom_range(lat_hi, lat_lo));
    end
    if (!rst_n) begin
      modelReset();
      return;
    end
    accept = m_req && imem_gnt;
    pop    = (mq_pc.size() != 0) && ready && !redirect;
    if (redirect) begin
      mq_pc.delete();
      mq_instr.delete();
      m_next_pc = {redirect_pc[31:2], 2'b00};
      if (m_out && !imem_rvalid) m_disc = 1'b1;
      else begin
        m_out  = 1'b0;
        m_disc = 1'b0;
      end
    end else begin
      if (pop) begin
        void'(mq_pc.pop_front());
        void'(mq_instr.pop_front());
      end
      if (m_out && imem_rvalid) begin
        if (!m_disc) begin
          mq_pc.push_back(m_out_pc);
          mq_instr.push_back(imem_rdata);
        end
        m_out  = 1'b0;
        m_disc = 1'b0;
      end
      if (accept) begin
        m_out     = 1'b1;
        m_out_pc  = m_next_pc;
        m_next_pc = m_next_pc + 32'd4;
      end
    end
  endtask

  task automatic cycleBegin();
    @(negedge clk);
    applyStimulus();
    #1;
    compareModel();
  endtask

  task automatic cycleEnd();
    updateModel();
    @(posedge clk);
  endtask

  task automatic doReset();
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    ready          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    force_redirect = 1'b0;
    force_target   = 32'h0;
    redir_pct      = 0;
    seq_on         = 1'b0;
    mem_busy       = 1'b0;
    mem_cnt        = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    // Reset release, streaming, then a decode stall with ordered continuation.
    doReset();
    lat_lo = 1; lat_hi = 1; gnt_pct = 100; rdy_pct = 100;
    seq_on = 1'b1; seq_n = 0;
    for (int c = 0; c < 12; c++) begin
      cycleBegin();
      if (c == 0) begin
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_instr", instr, 32'h0000_0013);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_pcplus4", pcplus4, 32'd4);
        checkOutput("rst_req", 32'(imem_req), 32'd1);
        checkOutput("rst_addr", imem_addr, RESET_PC);
      end
      if (c == 2) begin
        checkOutput("first_valid", 32'(valid), 32'd1);
        checkOutput("first_pc", pc, 32'h0);
        checkOutput("first_instr", instr, 32'h0000_A000);
      end
      cycleEnd();
    end
    rdy_pct = 0;
    for (int s = 0; s < 5; s++) begin
      cycleBegin();
      if (s == 4) begin
        checkOutput("stall_req", 32'(imem_req), 32'd0);
        checkOutput("stall_valid", 32'(valid), 32'd1);
      end
      cycleEnd();
    end
    rdy_pct = 100;
    for (int s = 0; s < 10; s++) begin
      cycleBegin();
      cycleEnd();
    end
    seq_on = 1'b0;

    // Redirect while waiting on a 3-cycle response for 0x8.
    doReset();
    lat_lo = 3; lat_hi = 3; gnt_pct = 100; rdy_pct = 100;
    for (int c = 0; c < 15; c++) begin
      force_redirect = (c == 7);
      force_target   = 32'h0000_0103;
      cycleBegin();
      if (c == 6) begin
        checkOutput("wait_req8", 32'(imem_req), 32'd1);
        checkOutput("wait_addr8", imem_addr, 32'h8);
      end
      if (c == 8)  checkOutput("wait_flush_valid", 32'(valid), 32'd0);
      if (c == 10) begin
        checkOutput("wait_target_req", 32'(imem_req), 32'd1);
        checkOutput("wait_target_addr", imem_addr, 32'h100);
      end
      if (c == 13) checkOutput("wait_no_early_valid", 32'(valid), 32'd0);
      if (c == 14) begin
        checkOutput("wait_target_valid", 32'(valid), 32'd1);
        checkOutput("wait_target_pc", pc, 32'h100);
        checkOutput("wait_target_instr", instr, 32'h0000_A100);
      end
      cycleEnd();
    end
    force_redirect = 1'b0;

    // Redirect coinciding with a response while the FIFO already holds an entry.
    doReset();
    lat_lo = 1; lat_hi = 1; gnt_pct = 100; rdy_pct = 0;
    for (int c = 0; c < 4; c++) begin
      force_redirect = (c == 2);
      force_target   = 32'h0000_0200;
      cycleBegin();
      if (c == 2) checkOutput("rv_redir_pre_valid", 32'(valid), 32'd1);
      if (c == 3) begin
        checkOutput("rv_redir_valid", 32'(valid), 32'd0);
        checkOutput("rv_redir_req", 32'(imem_req), 32'd1);
        checkOutput("rv_redir_addr", imem_addr, 32'h200);
      end
      cycleEnd();
    end
    force_redirect = 1'b0;

    // Wrap-around at the top of the address space.
    doReset();
    lat_lo = 1; lat_hi = 1; gnt_pct = 100; rdy_pct = 100;
    for (int c = 0; c < 5; c++) begin
      force_redirect = (c == 0);
      force_target   = 32'hFFFF_FFFC;
      cycleBegin();
      if (c == 0) checkOutput("wrap_no_req", 32'(imem_req), 32'd0);
      if (c == 1) checkOutput("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
      if (c == 2) begin
        checkOutput("wrap_req0", 32'(imem_req), 32'd1);
        checkOutput("wrap_addr0", imem_addr, 32'h0);
      end
      if (c == 3) begin
        checkOutput("wrap_pc", pc, 32'hFFFF_FFFC);
        checkOutput("wrap_pcplus4", pcplus4, 32'h0);
        checkOutput("wrap_instr", instr, 32'hFFFF_FFFC);
      end
      cycleEnd();
    end
    force_redirect = 1'b0;

    // Asynchronous reset mid-WAIT followed by a stray response.
    doReset();
    lat_lo = 3; lat_hi = 3; gnt_pct = 100; rdy_pct = 100;
    for (int c = 0; c < 2; c++) begin
      cycleBegin();
      cycleEnd();
    end
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_valid", 32'(valid), 32'd0);
    checkOutput("async_instr", instr, 32'h0000_0013);
    checkOutput("async_pc", pc, 32'h0);
    checkOutput("async_pcplus4", pcplus4, 32'd4);
    checkOutput("async_addr", imem_addr, RESET_PC);
    gnt_pct = 0;
    cycleBegin();
    cycleEnd();
    #2 rst_n = 1'b1;
    cycleBegin();
    checkOutput("stray_rvalid_seen", 32'(imem_rvalid), 32'd1);
    checkOutput("stray_req", 32'(imem_req), 32'd1);
    checkOutput("stray_addr", imem_addr, RESET_PC);
    cycleEnd();
    cycleBegin();
    checkOutput("stray_not_pushed", 32'(valid), 32'd0);
    cycleEnd();
    gnt_pct = 100;
    for (int c = 0; c < 8; c++) begin
      cycleBegin();
      cycleEnd();
    end

    // Randomized traffic: variable latency, grant/ready back-pressure and redirects.
    doReset();
    lat_lo = 1; lat_hi = 3; gnt_pct = 70; rdy_pct = 70; redir_pct = 5;
    for (int c = 0; c < 4000; c++) begin
      cycleBegin();
      cycleEnd();
    end
    lat_lo = 1; lat_hi = 1; gnt_pct = 100; rdy_pct = 100; redir_pct = 2;
    for (int c = 0; c < 1000; c++) begin
      cycleBegin();
      cycleEnd();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
